// File: rtl/div_sched_pkg.sv
// Shared types and constants for the GF(2^31-1) divider scheduler.
package div_sched_pkg;

    localparam int W = 31;
    localparam logic [W-1:0] P_MOD = 31'h7fffffff;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESP
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK      = 2'd0,
        ERR_DIVZERO = 2'd1,
        ERR_TIMEOUT = 2'd2
    } err_t;

    // The modulus itself reduces to zero, so it is screened like a literal zero.
    function automatic logic is_zero_mod(input logic [W-1:0] b);
        return (b == '0) || (b == P_MOD);
    endfunction

endpackage

// File: rtl/div_sched_rr_arbiter.sv
// Round-robin arbiter: the first requesting index after ptr wins, wrapping around.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 1; i <= N; i++) begin
            j = (int'(ptr) + i) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/div_sched.sv
// Shares one variable-latency modular divider among N_REQ requesters with
// round-robin arbitration, divide-by-zero screening and a completion watchdog.
module div_sched
    import div_sched_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  TIMEOUT = 1024,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [W-1:0]       rsp_data,
    output logic [1:0]         rsp_err,
    output logic               div_opselect,
    output logic [W-1:0]       div_a,
    output logic [W-1:0]       div_b,
    input  logic [W-1:0]       div_result,
    input  logic               div_rdy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  win_idx;
    logic [N_REQ-1:0] win_grant;
    logic             win_any;
    logic [W-1:0]     win_a;
    logic [W-1:0]     win_b;
    logic             win_zero;
    logic             dispatch;
    logic             timeout_hit;
    logic [CNT_W-1:0] cnt;

    rr_arbiter #(
        .N    (N_REQ),
        .ID_W (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    assign win_a       = req_a[int'(win_idx)*W +: W];
    assign win_b       = req_b[int'(win_idx)*W +: W];
    assign win_zero    = is_zero_mod(win_b);
    // The divider has no reset, so its ready flag gates every dispatch.
    assign dispatch    = rst_n && (state == IDLE) && win_any && div_rdy;
    assign req_ready   = dispatch ? win_grant : '0;
    assign timeout_hit = (cnt == CNT_LAST);
    assign rsp_valid   = (state == RESP);
    assign div_opselect = (state == ISSUE);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (dispatch) state_next = win_zero ? RESP : ISSUE;
            ISSUE:     state_next = WAIT_BUSY;
            WAIT_BUSY: begin
                if (timeout_hit)   state_next = RESP;
                else if (!div_rdy) state_next = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (div_rdy || timeout_hit) state_next = RESP;
            end
            RESP:      if (rsp_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= ID_W'(N_REQ - 1);
            cnt      <= '0;
            div_a    <= '0;
            div_b    <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            rsp_err  <= ERR_OK;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (dispatch) begin
                        div_a    <= win_a;
                        div_b    <= win_b;
                        rsp_id   <= win_idx;
                        rsp_data <= '0;
                        rsp_err  <= win_zero ? ERR_DIVZERO : ERR_OK;
                        cnt      <= '0;
                    end
                end
                ISSUE: cnt <= cnt + CNT_W'(1);
                WAIT_BUSY: begin
                    cnt <= cnt + CNT_W'(1);
                    if (timeout_hit) rsp_err <= ERR_TIMEOUT;
                end
                WAIT_DONE: begin
                    cnt <= cnt + CNT_W'(1);
                    if (div_rdy)          rsp_data <= div_result;
                    else if (timeout_hit) rsp_err  <= ERR_TIMEOUT;
                end
                RESP: if (rsp_ready) ptr <= rsp_id;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched with a behavioural GF(2^31-1) divider model.
module tb_div_sched;
    import div_sched_pkg::*;

    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int TMO  = 16;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [ID_W-1:0] rsp_id;
    logic [W-1:0]   rsp_data;
    logic [1:0]     rsp_err;
    logic           div_opselect;
    logic [W-1:0]   div_a;
    logic [W-1:0]   div_b;
    logic [W-1:0]   div_result = '0;
    logic           div_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    div_sched #(
        .N_REQ   (N),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .div_opselect (div_opselect),
        .div_a        (div_a),
        .div_b        (div_b),
        .div_result   (div_result),
        .div_rdy      (div_rdy)
    );

    // behavioural divider: a * b^(p-2) mod p after a programmable latency
    function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [63:0] t;
        t = 64'(x) * 64'(y);
        return W'(t % 64'h7fffffff);
    endfunction

    function automatic logic [W-1:0] divmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [W-1:0] base;
        logic [W-1:0] e;
        r    = 31'd1;
        base = b;
        e    = 31'h7ffffffd;
        while (e != '0) begin
            if (e[0]) r = mulmod(r, base);
            base = mulmod(base, base);
            e    = e >> 1;
        end
        return mulmod(a, r);
    endfunction

    logic div_rdy_m = 1'b1;
    logic m_busy    = 1'b0;
    int   m_cnt     = 0;
    int   lat       = 3;
    logic stuck     = 1'b0;
    logic hold_low  = 1'b0;
    int   op_count  = 0;

    assign div_rdy = div_rdy_m & ~hold_low;

    always @(posedge clk) begin
        if (div_opselect) begin
            op_count   <= op_count + 1;
            m_busy     <= 1'b1;
            m_cnt      <= lat;
            div_rdy_m  <= 1'b0;
            div_result <= divmod(div_a, div_b);
        end else if (m_busy && !stuck) begin
            if (m_cnt == 0) begin
                m_busy    <= 1'b0;
                div_rdy_m <= 1'b1;
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    // monitor + scoreboard for the fairness run
    logic       mon_en = 1'b0;
    int         grant_q[$];
    int         rspid_q[$];
    logic [W-1:0] rspd_q[$];
    logic [W-1:0] exp_q[$];

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            for (int i = 0; i < N; i++) if (req_ready[i]) grant_q.push_back(i);
            if (rsp_valid && rsp_ready) begin
                rspid_q.push_back(int'(rsp_id));
                rspd_q.push_back(rsp_data);
            end
        end
    end

    // driver tasks
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i]     = 1'b1;
        req_a[i*W +: W]  = a;
        req_b[i*W +: W]  = b;
    endtask

    task automatic clr_reqs();
        req_valid = '0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rsp(input int budget, output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < budget) begin
            cyc();
            cycles++;
        end
        check("rsp_wait", 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int exp_grant[5];
        exp_grant = '{0, 1, 2, 3, 0};

        // reset with every requester valid: nothing may be granted
        for (int i = 0; i < N; i++) set_req(i, 31'(i + 1), 31'd1);
        repeat (3) cyc();
        #1;
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_opselect", 64'(div_opselect), 64'd0);
        check("rst_div_a", 64'(div_a), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        clr_reqs();
        rst_n = 1'b1;

        // 6 / 3 from requester 0
        set_req(0, 31'd6, 31'd3);
        #1;
        check("t1_grant", 64'(req_ready), 64'b0001);
        cyc();
        clr_reqs();
        check("t1_opselect", 64'(div_opselect), 64'd1);
        check("t1_div_a", 64'(div_a), 64'd6);
        check("t1_div_b", 64'(div_b), 64'd3);
        cyc();
        check("t1_opselect_low", 64'(div_opselect), 64'd0);
        wait_rsp(30, t);
        check("t1_rsp_id", 64'(rsp_id), 64'd0);
        check("t1_rsp_data", 64'(rsp_data), 64'd2);
        check("t1_rsp_err", 64'(rsp_err), 64'd0);
        check("t1_op_count", 64'(op_count), 64'd1);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("t1_rsp_drop", 64'(rsp_valid), 64'd0);

        // 1 / 2 from requester 2, still valid in the cycle after the grant
        set_req(2, 31'd1, 31'd2);
        #1;
        check("t2_grant", 64'(req_ready), 64'b0100);
        cyc();
        #1;
        check("t2_grant_one_cycle", 64'(req_ready), 64'd0);
        clr_reqs();
        wait_rsp(30, t);
        check("t2_rsp_id", 64'(rsp_id), 64'd2);
        check("t2_rsp_data", 64'(rsp_data), 64'h40000000);
        check("t2_rsp_err", 64'(rsp_err), 64'd0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;

        // divide by zero and by the modulus: immediate error, no opselect
        t = op_count;
        set_req(1, 31'd5, 31'd0);
        #1;
        check("t3a_grant", 64'(req_ready), 64'b0010);
        cyc();
        clr_reqs();
        check("t3a_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t3a_rsp_err", 64'(rsp_err), 64'd1);
        check("t3a_rsp_data", 64'(rsp_data), 64'd0);
        check("t3a_rsp_id", 64'(rsp_id), 64'd1);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("t3a_rsp_drop", 64'(rsp_valid), 64'd0);
        set_req(1, 31'd5, P_MOD);
        #1;
        check("t3b_grant", 64'(req_ready), 64'b0010);
        cyc();
        clr_reqs();
        check("t3b_rsp_valid", 64'(rsp_valid), 64'd1);
        check("t3b_rsp_err", 64'(rsp_err), 64'd1);
        check("t3b_rsp_data", 64'(rsp_data), 64'd0);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        check("t3_no_opselect", 64'(op_count), 64'(t));

        // fresh pointer, all requesters valid, responses always accepted
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 31'(10 + i), 31'd1);
        exp_q.push_back(31'd10);
        exp_q.push_back(31'd11);
        exp_q.push_back(31'd12);
        exp_q.push_back(31'd13);
        exp_q.push_back(31'd10);
        rsp_ready = 1'b1;
        mon_en = 1'b1;
        for (int k = 0; k < 200 && grant_q.size() < 5; k++) cyc();
        clr_reqs();
        for (int k = 0; k < 50 && rspd_q.size() < 5; k++) cyc();
        mon_en = 1'b0;
        rsp_ready = 1'b0;
        check("t4_grant_count", 64'(grant_q.size()), 64'd5);
        check("t4_rsp_count", 64'(rspd_q.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < grant_q.size()) check("t4_grant_order", 64'(grant_q[k]), 64'(exp_grant[k]));
            if (k < rspd_q.size()) begin
                check("t4_rsp_id", 64'(rspid_q[k]), 64'(exp_grant[k]));
                check("t4_rsp_data", 64'(rspd_q[k]), 64'(exp_q.pop_front()));
            end
        end

        // back-pressure: response held, competing request not granted
        set_req(3, 31'd77, 31'd1);
        #1;
        check("t5_grant", 64'(req_ready), 64'b1000);
        cyc();
        clr_reqs();
        wait_rsp(30, t);
        set_req(0, 31'd5, 31'd7);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("t5_hold_valid", 64'(rsp_valid), 64'd1);
            check("t5_hold_data", 64'(rsp_data), 64'd77);
            check("t5_hold_id", 64'(rsp_id), 64'd3);
            check("t5_no_grant", 64'(req_ready), 64'd0);
            cyc();
        end
        rsp_ready = 1'b1;
        stuck = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        #1;
        check("t5_turnaround_grant", 64'(req_ready), 64'b0001);

        // divider never completes: timeout error 16 cycles after issue
        cyc();
        clr_reqs();
        check("t6_opselect", 64'(div_opselect), 64'd1);
        wait_rsp(40, t);
        check("t6_latency", 64'(t), 64'(TMO));
        check("t6_rsp_err", 64'(rsp_err), 64'd2);
        check("t6_rsp_data", 64'(rsp_data), 64'd0);
        check("t6_rsp_id", 64'(rsp_id), 64'd0);
        set_req(2, 31'd9, 31'd3);
        rsp_ready = 1'b1;
        cyc();
        rsp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t6_blocked", 64'(req_ready), 64'd0);
            cyc();
        end
        lat = 8;
        stuck = 1'b0;
        t = 0;
        #1;
        while (req_ready == '0 && t < 20) begin
            cyc();
            #1;
            t++;
        end
        check("t6_regrant", 64'(req_ready), 64'b0100);
        check("t6_regrant_rdy", 64'(div_rdy), 64'd1);
        check("t6_late_ignored", 64'(rsp_valid), 64'd0);

        // reset while waiting for the divider: transaction abandoned
        cyc();
        clr_reqs();
        cyc();
        cyc();
        cyc();
        rst_n = 1'b0;
        hold_low = 1'b1;
        cyc();
        for (int i = 0; i < N; i++) set_req(i, 31'd4, 31'd2);
        #1;
        check("t7_rsp_valid", 64'(rsp_valid), 64'd0);
        check("t7_req_ready", 64'(req_ready), 64'd0);
        check("t7_opselect", 64'(div_opselect), 64'd0);
        check("t7_div_a", 64'(div_a), 64'd0);
        check("t7_div_b", 64'(div_b), 64'd0);
        check("t7_rsp_data", 64'(rsp_data), 64'd0);
        check("t7_rsp_err", 64'(rsp_err), 64'd0);
        check("t7_rsp_id", 64'(rsp_id), 64'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cyc();
            #1;
            check("t8_no_grant", 64'(req_ready), 64'd0);
            check("t8_no_rsp", 64'(rsp_valid), 64'd0);
        end
        hold_low = 1'b0;
        #1;
        check("t8_first_grant", 64'(req_ready), 64'b0001);
        cyc();
        clr_reqs();
        rsp_ready = 1'b1;
        wait_rsp(40, t);
        check("t8_rsp_id", 64'(rsp_id), 64'd0);
        check("t8_rsp_data", 64'(rsp_data), 64'd2);
        check("t8_rsp_err", 64'(rsp_err), 64'd0);
        cyc();
        rsp_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
